pattern_select: RTL and testbench

Debounced two-key pattern selector for the HDMI 1080p colorbar/test-pattern path. Pressing up or down steps `pix_num` through patterns 1..NUM_PAT, with wrap or saturate selectable and optional auto-repeat while a key is held. A one-cycle `pix_chg` strobe marks every change so the pattern generator can resync at the next frame. This block succeeds the single-key fixed-range selector: keys, range, debounce time and repeat behaviour are all parametrised.

---
 rtl/hdmi_pkg.sv | 22 ++
 rtl/key_debounce.sv | 107 ++++++++++
 rtl/pattern_select.sv | 99 +++++++++
 tb/tb_pattern_select.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hdmi_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// hdmi_pkg: constants and types shared across the HDMI test-pattern path
// Revision: 1.0
// ------------------------------------------------------------------
package hdmi_pkg;

  // 20 ms of key debounce at a 50 MHz system clock
  localparam int DEB_20MS_50M    = 1_000_000;
  localparam int PAT_NONE        = 0;
  localparam int NUM_PAT_DEFAULT = 4;

  typedef enum logic [1:0] {
    STEP_NONE = 2'b00,
    STEP_UP   = 2'b01,
    STEP_DN   = 2'b10,
    STEP_BOTH = 2'b11
  } step_e;

endpackage

`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ------------------------------------------------------------------
// key_debounce: 2-flop sync, saturating debounce and auto-repeat for one active-low key
// Revision: 1.0
// ------------------------------------------------------------------
module key_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int REPEAT_DLY   = 50_000_000,
  parameter int REPEAT_PER   = 10_000_000
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_n,
  output logic held,
  output logic step
);

  localparam int DEB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYC);
  localparam logic [DEB_W-1:0] DEB_ONE = DEB_W'(1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             fired_q, fired_d;
  logic             press;

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      deb_cnt_q <= '0;
      fired_q   <= 1'b0;
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      deb_cnt_q <= deb_cnt_d;
      fired_q   <= fired_d;
    end
  end

  always_comb begin
    sync1_d   = key_n;
    sync2_d   = sync1_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q != DEB_MAX) begin
      deb_cnt_d = deb_cnt_q + DEB_ONE;
    end
    // fired_q remembers the press so one low period yields one pulse
    fired_d = held;
  end

  assign held  = (deb_cnt_q == DEB_MAX);
  assign press = held & ~fired_q;

  if (REPEAT_DLY > 0) begin : g_repeat
    localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
    localparam int HOLD_W  = $clog2(REP_MAX + 1);
    localparam logic [HOLD_W-1:0] DLY_V    = HOLD_W'(REPEAT_DLY);
    localparam logic [HOLD_W-1:0] PER_V    = HOLD_W'(REPEAT_PER);
    localparam logic [HOLD_W-1:0] HOLD_ONE = HOLD_W'(1);

    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              rep_phase_q, rep_phase_d;
    logic              rep;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        hold_cnt_q  <= '0;
        rep_phase_q <= 1'b0;
      end else begin
        hold_cnt_q  <= hold_cnt_d;
        rep_phase_q <= rep_phase_d;
      end
    end

    // Counter restarts at 1 after each pulse; phase selects first delay vs period
    always_comb begin
      hold_cnt_d  = hold_cnt_q;
      rep_phase_d = rep_phase_q;
      rep         = 1'b0;
      if (!held || sync2_q) begin
        hold_cnt_d  = '0;
        rep_phase_d = 1'b0;
      end else if (press) begin
        hold_cnt_d = HOLD_ONE;
      end else if (hold_cnt_q != '0) begin
        if (hold_cnt_q == (rep_phase_q ? PER_V : DLY_V)) begin
          rep         = 1'b1;
          hold_cnt_d  = HOLD_ONE;
          rep_phase_d = 1'b1;
        end else begin
          hold_cnt_d = hold_cnt_q + HOLD_ONE;
        end
      end
    end

    assign step = press | rep;
  end else begin : g_no_repeat
    assign step = press;
  end

endmodule

`default_nettype wire

// File: rtl/pattern_select.sv
`default_nettype none
// ------------------------------------------------------------------
// pattern_select: two-key debounced up/down selector of the active test pattern
// Revision: 1.0
// ------------------------------------------------------------------
module pattern_select
  import hdmi_pkg::*;
#(
  parameter int DEBOUNCE_CYC = DEB_20MS_50M,
  parameter int NUM_PAT      = NUM_PAT_DEFAULT,
  parameter int SEL_W        = 4,
  parameter int WRAP         = 1,
  parameter int REPEAT_DLY   = 50_000_000,
  parameter int REPEAT_PER   = 10_000_000
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             key_up,
  input  logic             key_dn,
  output logic [SEL_W-1:0] pix_num,
  output logic             pix_chg,
  output logic [1:0]       key_held
);

  localparam logic [SEL_W:0]   PAT_MAX   = (SEL_W + 1)'(NUM_PAT);
  localparam logic [SEL_W:0]   PAT_FIRST = (SEL_W + 1)'(1);
  localparam logic [SEL_W:0]   PAT_ZERO  = (SEL_W + 1)'(PAT_NONE);
  localparam logic [SEL_W-1:0] PIX_RST   = SEL_W'(PAT_NONE);

  logic             up_step, dn_step;
  logic             up_held, dn_held;
  step_e            step_dir;
  logic [SEL_W:0]   cur, nxt;
  logic [SEL_W-1:0] pix_num_q, pix_num_d;
  logic             pix_chg_q, pix_chg_d;

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_PER  (REPEAT_PER)
  ) u_key_up (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_n    (key_up),
    .held     (up_held),
    .step     (up_step)
  );

  key_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC),
    .REPEAT_DLY  (REPEAT_DLY),
    .REPEAT_PER  (REPEAT_PER)
  ) u_key_dn (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_n    (key_dn),
    .held     (dn_held),
    .step     (dn_step)
  );

  // One extra bit keeps the increment at 2^SEL_W-1 from aliasing before compare
  always_comb begin
    step_dir = step_e'({dn_step, up_step});
    cur      = {1'b0, pix_num_q};
    nxt      = cur;
    case (step_dir)
      STEP_UP: begin
        if (cur == PAT_ZERO)     nxt = PAT_FIRST;
        else if (cur >= PAT_MAX) nxt = (WRAP != 0) ? PAT_FIRST : PAT_MAX;
        else                     nxt = cur + PAT_FIRST;
      end
      STEP_DN: begin
        if (cur == PAT_ZERO)       nxt = PAT_MAX;
        else if (cur <= PAT_FIRST) nxt = (WRAP != 0) ? PAT_MAX : PAT_FIRST;
        else                       nxt = cur - PAT_FIRST;
      end
      default: nxt = cur;
    endcase
    pix_num_d = nxt[SEL_W-1:0];
    pix_chg_d = (nxt != cur);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      pix_num_q <= PIX_RST;
      pix_chg_q <= 1'b0;
    end else begin
      pix_num_q <= pix_num_d;
      pix_chg_q <= pix_chg_d;
    end
  end

  assign pix_num  = pix_num_q;
  assign pix_chg  = pix_chg_q;
  assign key_held = {dn_held, up_held};

endmodule

`default_nettype wire

// File: tb/tb_pattern_select.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pattern_select: directed vectors over wrap, saturate and single-pattern instances
// Revision: 1.0
// ------------------------------------------------------------------
module tb_pattern_select;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       key_up    = 1'b1;
  logic       key_dn    = 1'b1;
  logic [3:0] pix_w, pix_s, pix_o;
  logic       chg_w, chg_s, chg_o;
  logic [1:0] held_w, held_s, held_o;

  int n_cmp = 0;
  int n_err = 0;
  int cnt_w = 0, cnt_s = 0, cnt_o = 0;

  typedef struct {
    logic       up_n;
    logic       dn_n;
    int         hold;
    logic [3:0] e_w, e_s, e_o;
    int         c_w, c_s, c_o;
  } vec_t;

  vec_t vecs[9];

  always #5 sys_clk = ~sys_clk;

  pattern_select #(.DEBOUNCE_CYC(8), .NUM_PAT(4), .SEL_W(4), .WRAP(1),
                   .REPEAT_DLY(20), .REPEAT_PER(5)) dut_wrap (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_up(key_up), .key_dn(key_dn),
    .pix_num(pix_w), .pix_chg(chg_w), .key_held(held_w));

  pattern_select #(.DEBOUNCE_CYC(8), .NUM_PAT(4), .SEL_W(4), .WRAP(0),
                   .REPEAT_DLY(20), .REPEAT_PER(5)) dut_sat (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_up(key_up), .key_dn(key_dn),
    .pix_num(pix_s), .pix_chg(chg_s), .key_held(held_s));

  pattern_select #(.DEBOUNCE_CYC(8), .NUM_PAT(1), .SEL_W(4), .WRAP(1),
                   .REPEAT_DLY(20), .REPEAT_PER(5)) dut_one (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_up(key_up), .key_dn(key_dn),
    .pix_num(pix_o), .pix_chg(chg_o), .key_held(held_o));

  always @(negedge sys_clk) begin
    cnt_w <= cnt_w + int'(chg_w);
    cnt_s <= cnt_s + int'(chg_s);
    cnt_o <= cnt_o + int'(chg_o);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(negedge sys_clk);
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    key_up    = 1'b1;
    key_dn    = 1'b1;
    edges(2);
    sys_rst_n = 1'b1;
    edges(1);
  endtask

  task automatic press(input logic u, input logic d, input int hold);
    key_up = u;
    key_dn = d;
    edges(hold);
    key_up = 1'b1;
    key_dn = 1'b1;
    edges(4);
  endtask

  // Down steps from 0 on a 4-pattern wrapping selector: 4,3,2,1,4,...
  function automatic int dn_model(input int n);
    return (n == 0) ? 0 : 4 - ((n - 1) % 4);
  endfunction

  initial begin
    int b_w, b_s, b_o, n_exp;

    vecs[0] = '{1'b0, 1'b1, 12, 4'd2, 4'd2, 4'd1, 1, 1, 0};
    vecs[1] = '{1'b0, 1'b1, 12, 4'd3, 4'd3, 4'd1, 1, 1, 0};
    vecs[2] = '{1'b0, 1'b1, 12, 4'd4, 4'd4, 4'd1, 1, 1, 0};
    vecs[3] = '{1'b0, 1'b1, 12, 4'd1, 4'd4, 4'd1, 1, 0, 0};
    vecs[4] = '{1'b1, 1'b0, 12, 4'd4, 4'd3, 4'd1, 1, 1, 0};
    vecs[5] = '{1'b1, 1'b0, 12, 4'd3, 4'd2, 4'd1, 1, 1, 0};
    vecs[6] = '{1'b1, 1'b0, 12, 4'd2, 4'd1, 4'd1, 1, 1, 0};
    vecs[7] = '{1'b1, 1'b0, 12, 4'd1, 4'd1, 4'd1, 1, 0, 0};
    vecs[8] = '{1'b1, 1'b0, 12, 4'd4, 4'd1, 4'd1, 1, 0, 0};

    do_reset();
    chk("reset pix_num", pix_w, 0);
    chk("reset pix_chg", chg_w, 0);
    chk("reset key_held", held_w, 0);
    chk("reset pix_num sat", pix_s, 0);

    // Single press: new value lands on the 11th edge after the first low sample
    b_w = cnt_w;
    key_up = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      edges(1);
      if (e == 10) chk("single pix_num before", pix_w, 0);
      if (e == 11) begin
        chk("single pix_num", pix_w, 1);
        chk("single pix_chg high", chg_w, 1);
        chk("single key_held", held_w, 1);
      end
      if (e == 12) chk("single pix_chg low", chg_w, 0);
    end
    key_up = 1'b1;
    edges(4);
    chk("single chg count", cnt_w - b_w, 1);
    chk("single key_held released", held_w, 0);
    chk("single one pix_num", pix_o, 1);

    // Bounce: 5 low / 1 high never qualifies an 8-cycle debounce
    b_w = cnt_w;
    for (int i = 0; i < 10; i++) begin
      key_up = 1'b0;
      edges(5);
      key_up = 1'b1;
      edges(1);
    end
    edges(4);
    chk("bounce pix_num", pix_w, 1);
    chk("bounce chg count", cnt_w - b_w, 0);

    // Wrap / saturate / single-pattern table
    for (int i = 0; i < 9; i++) begin
      b_w = cnt_w; b_s = cnt_s; b_o = cnt_o;
      key_up = vecs[i].up_n;
      key_dn = vecs[i].dn_n;
      edges(vecs[i].hold);
      chk($sformatf("vec%0d key_held", i), held_w, {~vecs[i].dn_n, ~vecs[i].up_n});
      key_up = 1'b1;
      key_dn = 1'b1;
      edges(4);
      chk($sformatf("vec%0d pix wrap", i), pix_w, vecs[i].e_w);
      chk($sformatf("vec%0d pix sat", i), pix_s, vecs[i].e_s);
      chk($sformatf("vec%0d pix one", i), pix_o, vecs[i].e_o);
      chk($sformatf("vec%0d chg wrap", i), cnt_w - b_w, vecs[i].c_w);
      chk($sformatf("vec%0d chg sat", i), cnt_s - b_s, vecs[i].c_s);
      chk($sformatf("vec%0d chg one", i), cnt_o - b_o, vecs[i].c_o);
    end

    // Auto-repeat: press at edge 11, repeats land at edge 31 then every 5
    do_reset();
    b_w = cnt_w; b_s = cnt_s; b_o = cnt_o;
    key_dn = 1'b0;
    for (int e = 1; e <= 60; e++) begin
      edges(1);
      n_exp = ((e >= 11) ? 1 : 0) + ((e >= 31) ? 1 + (e - 31) / 5 : 0);
      chk($sformatf("repeat pix e%0d", e), pix_w, dn_model(n_exp));
    end
    key_dn = 1'b1;
    edges(10);
    chk("repeat final pix", pix_w, dn_model(8));
    chk("repeat chg count", cnt_w - b_w, 8);
    chk("repeat sat pix", pix_s, 1);
    chk("repeat sat chg count", cnt_s - b_s, 4);
    chk("repeat one pix", pix_o, 1);
    chk("repeat one chg count", cnt_o - b_o, 1);

    // Simultaneous keys cancel
    b_w = cnt_w; b_s = cnt_s;
    key_up = 1'b0;
    key_dn = 1'b0;
    edges(10);
    chk("both key_held", held_w, 3);
    chk("both key_held sat", held_s, 3);
    chk("both key_held one", held_o, 3);
    edges(2);
    key_up = 1'b1;
    key_dn = 1'b1;
    edges(4);
    chk("both pix_num", pix_w, 1);
    chk("both chg count", cnt_w - b_w, 0);
    chk("both chg count sat", cnt_s - b_s, 0);

    // Reset mid-press, key kept held across release
    do_reset();
    press(1'b0, 1'b1, 12);
    press(1'b0, 1'b1, 12);
    key_up = 1'b0;
    edges(15);
    chk("midrst pix before", pix_w, 3);
    #2 sys_rst_n = 1'b0;
    #1;
    chk("midrst pix async", pix_w, 0);
    chk("midrst key_held async", held_w, 0);
    edges(2);
    sys_rst_n = 1'b1;
    for (int e = 1; e <= 11; e++) begin
      edges(1);
      if (e == 10) chk("midrst pix not yet", pix_w, 0);
      if (e == 11) chk("midrst pix redebounced", pix_w, 1);
    end
    key_up = 1'b1;
    edges(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
